// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback_if
// Description : Handshake and query bundle for the register file write-side
//               front end. The master side is the pipeline (producers and
//               decode); the slave side is rf_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_if;
  // ALU result channel
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  // Load/CSR result channel
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  // Long-latency issue channel
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  // Decode scoreboard queries
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  // Register file write port
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  wen, rd, wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output wen, rd, wdata
  );
endinterface
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback
// Description : Merges single-cycle ALU results and variable-latency load
//               results into the single register file write port. Loads are
//               buffered in a small FIFO; a per-register pending scoreboard
//               lets decode hold instructions on outstanding writes.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback #(
  parameter int MEM_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_writeback_if.slave bus
);

  localparam int              c_AW      = $clog2(MEM_DEPTH);
  localparam logic [c_AW:0]   c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  // FIFO storage and pointers (extra MSB is the wrap bit)
  logic [4:0]    r_fifo_rd   [MEM_DEPTH];
  logic [31:0]   r_fifo_data [MEM_DEPTH];
  logic [c_AW:0] r_wptr;
  logic [c_AW:0] r_rptr;

  // Scoreboard and output register
  logic [31:0]   r_pending;
  logic          r_wen;
  logic [4:0]    r_rd;
  logic [31:0]   r_wdata;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_sel_valid;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic          w_issue_ready;
  logic          w_issue_set;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_clr_mask;
  logic [31:0]   w_pending_nxt;
  logic          w_write;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

  assign w_head_rd   = r_fifo_rd[r_rptr[c_AW-1:0]];
  assign w_head_data = r_fifo_data[r_rptr[c_AW-1:0]];

  // Ready signals depend on FIFO/scoreboard state only, never on valid
  assign w_push        = bus.mem_valid && !w_full;
  assign w_issue_ready = !r_pending[bus.issue_rd];
  assign w_issue_set   = bus.issue_valid && w_issue_ready && (bus.issue_rd != 5'd0);

  assign bus.mem_ready   = !w_full;
  assign bus.alu_ready   = !w_full;
  assign bus.issue_ready = w_issue_ready;

  // The output-register term bridges the cycle between pending clearing and
  // the register file actually committing the value.
  assign bus.rs1_busy = r_pending[bus.rs1] ||
                        (r_wen && (r_rd == bus.rs1) && (bus.rs1 != 5'd0));
  assign bus.rs2_busy = r_pending[bus.rs2] ||
                        (r_wen && (r_rd == bus.rs2) && (bus.rs2 != 5'd0));

  assign bus.wen   = r_wen;
  assign bus.rd    = r_rd;
  assign bus.wdata = r_wdata;

  // Arbitration: a full FIFO drains first so ALU traffic cannot starve loads
  always_comb begin
    w_pop       = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_rd    = 5'd0;
    w_sel_data  = 32'd0;
    if (w_full) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_rd    = w_head_rd;
      w_sel_data  = w_head_data;
    end else if (bus.alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.alu_rd;
      w_sel_data  = bus.alu_data;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_rd    = w_head_rd;
      w_sel_data  = w_head_data;
    end
  end

  // x0 results consume their slot but never reach the register file
  assign w_write = w_sel_valid && (w_sel_rd != 5'd0);

  // Scoreboard next state: set is applied after clear so it wins on a tie
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (w_pop) begin
      w_clr_mask[w_head_rd] = 1'b1;
    end
    if (w_issue_set) begin
      w_set_mask[bus.issue_rd] = 1'b1;
    end
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  // FIFO payload storage, written on every accepted load
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr[c_AW-1:0]]   <= bus.mem_rd;
      r_fifo_data[r_wptr[c_AW-1:0]] <= bus.mem_data;
    end
  end

  // FIFO pointers, scoreboard and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= 32'd0;
      r_wen     <= 1'b0;
      r_rd      <= 5'd0;
      r_wdata   <= 32'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      r_pending <= w_pending_nxt;
      r_wen     <= w_write;
      r_rd      <= w_write ? w_sel_rd : 5'd0;
      r_wdata   <= w_write ? w_sel_data : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_writeback
// Description : Self-checking bench for rf_writeback. A queue-based model of
//               the load buffer, a pending bit array and an expected write
//               port predict every cycle; directed scenarios are followed by
//               randomized traffic with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_writeback_if bus ();

  rf_writeback #(.MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [36:0] mq[$];
  logic [31:0] pend;
  logic        e_wen;
  logic [4:0]  e_rd;
  logic [31:0] e_wdata;
  bit          alu_acc, mem_acc, iss_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = 5'd0;
    bus.mem_data    = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
  endtask

  // One clock: check combinational outputs, predict, advance, check write port
  task automatic cycle();
    bit          full, push, sv, pop, ir;
    logic [36:0] head;
    logic [4:0]  srd;
    logic [31:0] sdata;
    #2;
    full = (mq.size() == DEPTH);
    ir   = (bus.issue_rd == 5'd0) || !pend[bus.issue_rd];
    chk("mem_ready", bus.mem_ready, !full);
    chk("alu_ready", bus.alu_ready, !full);
    chk("issue_ready", bus.issue_ready, ir);
    chk("rs1_busy", bus.rs1_busy,
        pend[bus.rs1] || (e_wen && e_rd == bus.rs1 && bus.rs1 != 5'd0));
    chk("rs2_busy", bus.rs2_busy,
        pend[bus.rs2] || (e_wen && e_rd == bus.rs2 && bus.rs2 != 5'd0));
    push  = bus.mem_valid && !full;
    sv    = 1'b0;
    pop   = 1'b0;
    srd   = 5'd0;
    sdata = 32'd0;
    if (full || (!bus.alu_valid && mq.size() > 0)) begin
      head  = mq.pop_front();
      sv    = 1'b1;
      pop   = 1'b1;
      srd   = head[36:32];
      sdata = head[31:0];
    end else if (bus.alu_valid) begin
      sv    = 1'b1;
      srd   = bus.alu_rd;
      sdata = bus.alu_data;
    end
    if (push) mq.push_back({bus.mem_rd, bus.mem_data});
    alu_acc = bus.alu_valid && !full;
    mem_acc = push;
    iss_acc = bus.issue_valid && ir;
    if (pop) pend[srd] = 1'b0;
    if (iss_acc && bus.issue_rd != 5'd0) pend[bus.issue_rd] = 1'b1;
    e_wen   = sv && (srd != 5'd0);
    e_rd    = e_wen ? srd : 5'd0;
    e_wdata = sdata;
    @(posedge clk);
    #1;
    chk("wen", bus.wen, e_wen);
    chk("rd", bus.rd, e_rd);
    if (e_wen) chk("wdata", bus.wdata, e_wdata);
  endtask

  // Assert reset (asynchronously, mid-cycle) and confirm everything clears
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    mq.delete();
    pend    = 32'd0;
    e_wen   = 1'b0;
    e_rd    = 5'd0;
    e_wdata = 32'd0;
    chk("rst_wen", bus.wen, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_mem_ready", bus.mem_ready, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_rs1_busy", bus.rs1_busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int pushes;
    idle_inputs();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    do_reset();

    // ALU path, then x0 destination
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'hDEADBEEF;
    cycle();
    chk("alu_wen_direct", bus.wen, 1);
    chk("alu_wdata_direct", bus.wdata, 32'hDEADBEEF);
    bus.alu_rd = 5'd0;
    cycle();
    chk("x0_wen_direct", bus.wen, 0);
    idle_inputs();
    cycle();

    // Issue to x3, re-issue is refused, load retires it
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    cycle();
    bus.rs1 = 5'd3;
    #1;
    chk("x3_busy_direct", bus.rs1_busy, 1);
    chk("x3_reissue_direct", bus.issue_ready, 0);
    cycle();
    bus.issue_valid = 1'b0;
    bus.mem_valid   = 1'b1;
    bus.mem_rd      = 5'd3;
    bus.mem_data    = 32'h1234;
    cycle();
    idle_inputs();
    cycle();
    chk("ld_wen_direct", bus.wen, 1);
    chk("ld_rd_direct", bus.rd, 3);
    chk("ld_busy_out_direct", bus.rs1_busy, 1);
    cycle();
    chk("ld_busy_after_direct", bus.rs1_busy, 0);

    // Continuous ALU traffic with four loads: fill, drain in order, resume
    pushes = 0;
    for (int i = 0; i < 14; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd20;
      bus.alu_data  = 32'hA000_0000 + i;
      bus.mem_valid = (pushes < 4);
      bus.mem_rd    = 5'(10 + pushes);
      bus.mem_data  = 32'hB000_0000 + pushes;
      cycle();
      if (mem_acc) pushes++;
      if (i == 3) chk("full_mem_ready_direct", bus.mem_ready, 0);
    end
    idle_inputs();
    cycle();

    // Pop of an x9 load coincides with a fresh issue to x9: set wins
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd9;
    bus.mem_data  = 32'h99;
    cycle();
    idle_inputs();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    bus.rs2         = 5'd9;
    cycle();
    bus.issue_valid = 1'b0;
    #1;
    chk("setclr_busy_direct", bus.rs2_busy, 1);
    cycle();

    // Build count 2 behind ALU traffic, then push and pop together
    for (int i = 0; i < 2; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd21;
      bus.alu_data  = 32'hC0 + i;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(24 + i);
      bus.mem_data  = 32'hD0 + i;
      cycle();
    end
    bus.alu_valid = 1'b0;
    bus.mem_rd    = 5'd26;
    bus.mem_data  = 32'hD2;
    cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle();

    // Reset with three buffered loads and x5 pending
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    cycle();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd22;
      bus.alu_data  = 32'hE0 + i;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(5 + i);
      bus.mem_data  = 32'hF0 + i;
      cycle();
    end
    bus.rs1 = 5'd5;
    do_reset();
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic; offers are held until accepted
    alu_acc = 1'b1;
    mem_acc = 1'b1;
    iss_acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (alu_acc || !bus.alu_valid) begin
        bus.alu_valid = ($urandom_range(0, 1) == 1);
        bus.alu_rd    = 5'($urandom_range(0, 15));
        bus.alu_data  = $urandom;
      end
      if (mem_acc || !bus.mem_valid) begin
        bus.mem_valid = ($urandom_range(0, 2) == 0);
        bus.mem_rd    = 5'($urandom_range(0, 15));
        bus.mem_data  = $urandom;
      end
      if (iss_acc || !bus.issue_valid) begin
        bus.issue_valid = ($urandom_range(0, 3) == 0);
        bus.issue_rd    = 5'($urandom_range(0, 15));
      end
      bus.rs1 = 5'($urandom_range(0, 15));
      bus.rs2 = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        alu_acc = 1'b1;
        mem_acc = 1'b1;
        iss_acc = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
